// File: rtl/bitser_pkg.sv
// Shared definitions for the bit-serial bitwise sequencer: op encodings and FSM states.
package bitser_pkg;

    localparam logic [1:0] OP_NE  = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bitwiseblock.sv
// One-bit bitwise slice. Written behaviourally; it is equivalent to the NAND-only gate netlist.
// The chain flag leaves un-inverted; any inversion selected by op0 is applied downstream.
module bitwiseblock
    import bitser_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op1,
    input  logic op0,
    output logic q,
    output logic cout
);

    always_comb begin
        q = 1'b0;
        case ({op1, op0})
            OP_NE:   q = 1'b0;
            OP_XOR:  q = a ^ b;
            OP_AND:  q = a & b;
            OP_OR:   q = a | b;
            default: q = 1'b0;
        endcase
    end

    // op1 masks out positions where a=1, turning "any difference" into "b above a"
    assign cout = cin | ((a ^ b) & ~(op1 & a));

endmodule

// File: rtl/bitwise_serial_seq.sv
// Bit-serial sequencer driving one bitwiseblock LSB first, carrying the chain through a flop.
// Optional `zero` output is enabled by defining BITSER_ZERO_FLAG_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; result/flag hold the last operation
// SHIFT | one operand bit per edge through the slice, WIDTH edges total
// DONE  | one-cycle done pulse; a new start is accepted here as well
module bitwise_serial_seq
    import bitser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
`ifdef BITSER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [1:0]       op_r;
    logic             acc;
    logic             q;
    logic             cout;
`ifdef BITSER_ZERO_FLAG_EN
    logic             nz;
`endif

    bitwiseblock u_slice (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (acc),
        .op1  (op_r[1]),
        .op0  (op_r[0]),
        .q    (q),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            op_r   <= OP_NE;
            acc    <= 1'b0;
            result <= '0;
            flag   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b1;
`ifdef BITSER_ZERO_FLAG_EN
            nz     <= 1'b0;
            zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a_in;
                        sh_b  <= b_in;
                        op_r  <= op;
                        acc   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                        state <= SHIFT;
`ifdef BITSER_ZERO_FLAG_EN
                        nz    <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // LSB-first q enters at the top so it reaches its own weight after WIDTH shifts
                    result <= {q, result[WIDTH-1:1]};
                    acc    <= cout;
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
`ifdef BITSER_ZERO_FLAG_EN
                    nz     <= nz | q;
`endif
                    if (cnt == LAST) begin
                        flag  <= cout ^ op_r[0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        state <= DONE;
`ifdef BITSER_ZERO_FLAG_EN
                        zero  <= ~(nz | q);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_serial_seq.sv
// Directed bench for bitwise_serial_seq (WIDTH=8): vector table plus corner-case sequences.
// Checks the `zero` output too when BITSER_ZERO_FLAG_EN is defined.
module tb_bitwise_serial_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag;
`ifdef BITSER_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks = 0;
    int errors = 0;

    bitwise_serial_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
`ifdef BITSER_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         flg;
        logic         zro;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called just after an edge; the following edge accepts the request.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted from the last accepting/observed edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic f, input logic z);
        chk({tag, " result"}, 32'(result), 32'(r));
        chk({tag, " flag"}, 32'(flag), 32'(f));
`ifdef BITSER_ZERO_FLAG_EN
        chk({tag, " zero"}, 32'(zero), 32'(z));
`else
        if (z === 1'bx) $display("unreachable");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        //            op     a      b      result flag zero
        vecs[0] = '{2'b10, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0};
        vecs[6] = '{2'b01, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{2'b00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[8] = '{2'b10, 8'h00, 8'h80, 8'h00, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a_in  = '0;
        b_in  = '0;
        #2;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flag", 32'(flag), 32'd0);
`ifdef BITSER_ZERO_FLAG_EN
        chk("reset zero", 32'(zero), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            start_op(vecs[v].op, vecs[v].a, vecs[v].b);
            chk($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
            wait_done(lat);
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'd8);
            chk_out($sformatf("vec%0d", v), vecs[v].res, vecs[v].flg, vecs[v].zro);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d done pulse", v), 32'(done), 32'd0);
            chk($sformatf("vec%0d ready", v), 32'(ready), 32'd1);
        end

        // Result and flag hold across idle cycles
        repeat (4) @(posedge clk);
        #1;
        chk_out("idle hold", 8'h00, 1'b1, 1'b1);

        // Back-to-back: start during the DONE cycle
        start_op(2'b01, 8'hA5, 8'h0F);
        wait_done(lat);
        chk("b2b first latency", 32'(lat), 32'd8);
        chk_out("b2b first", 8'hAA, 1'b0, 1'b0);
        start_op(2'b10, 8'hF0, 8'h3C);
        chk("b2b accepted busy", 32'(busy), 32'd1);
        chk("b2b accepted done", 32'(done), 32'd0);
        wait_done(lat);
        chk("b2b done gap", 32'(lat + 1), 32'd9);
        chk_out("b2b second", 8'h30, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Start while busy is ignored
        start_op(2'b10, 8'hF0, 8'h3C);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        op    = 2'b11;
        a_in  = 8'h0F;
        b_in  = 8'hF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy start ready", 32'(ready), 32'd0);
        chk("busy start busy", 32'(busy), 32'd1);
        wait_done(lat);
        chk("busy start latency", 32'(lat), 32'd5);
        chk_out("busy start", 8'h30, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-SHIFT, observed before any further clock edge
        start_op(2'b11, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flag", 32'(flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset ready", 32'(ready), 32'd1);
        chk("post-reset done", 32'(done), 32'd0);
        start_op(2'b01, 8'hA5, 8'h0F);
        wait_done(lat);
        chk("post-reset latency", 32'(lat), 32'd8);
        chk_out("post-reset", 8'hAA, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
